// File: rtl/multicycle_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM, DATA_W-bit datapath, req/ack memory ports.
// Optional MUL (opcode 1100, one extra execute cycle) is enabled by defining MULTICYCLE_CPU_MUL_EN.
`timescale 1ns/1ps
module multicycle_cpu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       IR,
  output logic [DATA_W-1:0] ALUOut,
  output logic              instr_done,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
`ifdef MULTICYCLE_CPU_MUL_EN
    , S_MUL
`endif
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_NOR  = 4'h4, OP_NAND = 4'h5, OP_SLT  = 4'h6, OP_ADDI = 4'h7,
    OP_LW   = 4'h8, OP_SW   = 4'h9, OP_BEQ  = 4'hA, OP_BNE  = 4'hB,
    OP_MUL  = 4'hC, OP_HALT = 4'hF
  } op_t;

  localparam int XW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              run_q;
  logic [DATA_W-1:0] rf_q [4];

  logic [3:0]        op;
  logic [1:0]        rs, rt, rd, rf_waddr;
  logic [DATA_W-1:0] imm_x, alu_res, rf_wdata;
  logic [ADDR_W-1:0] pc_plus2, br_target;
  logic [XW-1:0]     alu_x;
  logic              rf_we;

  assign op        = ir_q[15:12];
  assign rs        = ir_q[11:10];
  assign rt        = ir_q[9:8];
  assign rd        = ir_q[7:6];
  assign imm_x     = DATA_W'($signed(ir_q[7:0]));
  assign pc_plus2  = pc_q + ADDR_W'(2);
  assign br_target = pc_plus2 + (ADDR_W'($signed(ir_q[7:0])) << 1);
  assign alu_x     = XW'(alu_q);

  // run_q keeps imem_req low through reset and rising only after the first post-reset edge.
  assign imem_req   = (state_q == S_FETCH) && run_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && (op == OP_SW);
  assign dmem_addr  = alu_x[ADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign PC         = pc_q;
  assign IR         = ir_q;
  assign ALUOut     = alu_q;
  assign halted     = (state_q == S_HALT);

  assign rf_waddr = (op == OP_ADDI || op == OP_LW) ? rt : rd;
  assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    alu_res = a_q + imm_x;
    case (op)
      OP_ADD:         alu_res = a_q + b_q;
      OP_SUB:         alu_res = a_q - b_q;
      OP_AND:         alu_res = a_q & b_q;
      OP_OR:          alu_res = a_q | b_q;
      OP_NOR:         alu_res = ~(a_q | b_q);
      OP_NAND:        alu_res = ~(a_q & b_q);
      OP_SLT:         alu_res = DATA_W'($signed(a_q) < $signed(b_q));
      OP_BEQ, OP_BNE: alu_res = a_q - b_q;
      default:        alu_res = a_q + imm_x;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    rf_we      = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_NAND, OP_SLT, OP_ADDI: begin
            alu_d   = alu_res;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = alu_res;
            state_d = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_d      = alu_res;
            pc_d       = ((alu_res == '0) == (op == OP_BEQ)) ? br_target : pc_plus2;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_HALT: begin
            instr_done = 1'b1;
            state_d    = S_HALT;
          end
`ifdef MULTICYCLE_CPU_MUL_EN
          OP_MUL: state_d = S_MUL;
`endif
          default: begin
            pc_d       = pc_plus2;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
`ifdef MULTICYCLE_CPU_MUL_EN
      S_MUL: begin
        alu_d   = a_q * b_q;
        state_d = S_WB;
      end
`endif
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_LW) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d       = pc_plus2;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we      = (rf_waddr != 2'd0);
        pc_d       = pc_plus2;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      run_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      run_q   <= 1'b1;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle 16-bit core. Fetches 16-bit instructions and executes them over 3–5 cycles through a Moore FSM with a `DATA_W`-bit datapath. Adds load/store and branches. Instruction and data memories sit outside the block, behind req/ack handshakes.

## Interface
- `DATA_W`, 16: datapath/register width, ≥ 8.
- `ADDR_W`, 16: byte-address width of PC and both memory ports.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out `ADDR_W`: fetch byte address (= PC).
- `imem_ack` in 1: fetch completes on an edge with `imem_req & imem_ack`.
- `imem_rdata` in 16: instruction word, valid with ack.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out `ADDR_W`: byte address (ALU result, low bits).
- `dmem_wdata` out `DATA_W`: store data.
- `dmem_ack` in 1: completes access on an edge with `dmem_req & dmem_ack`.
- `dmem_rdata` in `DATA_W`: load data, valid with ack.
- `PC` out `ADDR_W`: current instruction address.
- `IR` out 16: latched instruction.
- `ALUOut` out `DATA_W`: registered ALU result.
- `instr_done` out 1: one-cycle pulse in the final cycle of each retired instruction.
- `halted` out 1: high once HALT has executed.

## Operation
- Fields:
  - op = IR[15:12]; rs = IR[11:10]; rt = IR[9:8]; rd = IR[7:6].
  - imm = IR[7:0], sign-extended to `DATA_W`.
- Registers: 4 × `DATA_W`. r0 reads 0, and writes to it are discarded.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOR, 0101 NAND, 0110 SLT (signed); all write rd.
  - 0111 ADDI: rt = rs + imm.
  - 1000 LW: rt = mem[rs + imm].
  - 1001 SW: mem[rs + imm] = rt.
  - 1010 BEQ, 1011 BNE: compare rs with rt.
  - 1111 HALT.
  - All other opcodes are NOPs.
- Arithmetic wraps modulo 2^`DATA_W`. No overflow detection.
- PC steps by 2.
  - Branch target = PC + 2 + (imm << 1), computed in `ADDR_W` bits with wrap.
  - Branch is taken on equal (BEQ) / not equal (BNE).
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: hold `imem_req`, stay until ack, latch IR, go to DECODE.
  - DECODE: latch A = R[rs], B = R[rt].
  - EXEC:
    - ALU, branch resolve, latch ALUOut.
    - Next state: MEM for LW/SW; WB for ALU ops; FETCH for branch/NOP; HALT for HALT.
  - MEM: hold `dmem_req`, stay until ack. LW → WB with data latched; SW → FETCH.
  - WB: write the register file, PC += 2, go to FETCH.
  - HALT: absorbing. No requests are issued. Exit only through reset.
- PC update:
  - Updated in the retiring cycle (WB, SW's MEM, or EXEC for branch/NOP).
  - HALT does not advance PC.
- Request hold rule: while req is high, addr/we/wdata are stable and req cannot drop before ack.

## Timing
- Reset values: all outputs 0, registers 0, state FETCH.
- `imem_req` rises in the first cycle after reset deasserts.
- Zero-wait latencies (ack in the same cycle as req):
  - ALU op / ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch / NOP: 3 cycles.
  - HALT: 3 cycles to `halted` = 1.
- Each wait cycle of ack adds exactly 1 cycle.
- `instr_done` is high for exactly 1 cycle per instruction, including HALT; never high while in HALT afterwards.
- Reset mid-request: req drops immediately (async) and the access is abandoned. A late ack after reset is ignored.
- ack without req is ignored.
- Register write and PC update take effect at the same edge. The next DECODE sees the new value.

## Configuration
- `MULTICYCLE_CPU_MUL_EN`
  - Defined: opcode 1100 MUL, rd = low `DATA_W` bits of rs × rt. It adds one extra EXEC cycle, so latency is 5 at zero-wait.
  - Undefined: 1100 is a NOP (3 cycles), and no multiplier is synthesised.

## Test plan
- **Arithmetic program, zero-wait, `DATA_W` = 16.**
  - Stimulus: addi r1,r0,15; addi r2,r0,7; and r3,r1,r2; sub r2,r1,r3; or r2,r2,r3; add r3,r2,r3; nor r1,r2,r3; slt r1,r3,r2; slt r1,r2,r3.
  - Expected: ALUOut sequence 15,7,7,8,15,22,0xFFE0,0,1; 9 `instr_done` pulses; 36 cycles total; final r1=1, r2=15, r3=22.
- **Fetch wait states.**
  - Stimulus: `imem_ack` delayed 3 cycles on every fetch.
  - Expected: `imem_addr` and `imem_req` stable while waiting; each instruction takes +3 cycles; results unchanged.
- **Load/store.**
  - Stimulus: addi r1,r0,20; sw r1,4(r0); lw r2,4(r0).
  - Expected: store with `dmem_we` = 1, addr 4, wdata 20. Load with addr 4; with rdata 20, r2 = 20. LW retires 5 cycles after its fetch starts.
- **Branches.**
  - Stimulus: beq r1,r1,+2 at PC 6; bne r0,r0,+5.
  - Expected: beq → PC 12. bne → not taken, PC + 2. Branch → 3 cycles.
- **`DATA_W` = 32.**
  - Stimulus: addi r1,r0,-1; add r1,r1,r1; slt r2,r1,r0.
  - Expected: r1 = 0xFFFFFFFE; r2 = 1.
- **Reset and HALT.**
  - Reset during held `dmem_req`: req drops immediately, then PC=0, registers 0, refetch at address 0.
  - HALT: `halted` = 1, PC frozen, no further `imem_req` over 20 cycles.
